// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared widths, line type and FSM state encoding for main_memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int LINE_W   = 512;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 6;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/main_memory_line_storage.sv
// ============================================================================
// Module   : line_storage
// Brief    : DEPTH x 512-bit single-port line array, synchronous write,
//            registered read whose output holds until the next read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module line_storage
  import mem_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] idx,
  input  line_t            wr_data,
  output line_t            rd_data
);

  line_t mem [DEPTH];

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[idx];
    end
  end

endmodule

`default_nettype wire

// File: rtl/main_memory.sv
// ============================================================================
// Module   : main_memory
// Brief    : Latency-programmable line read/write responder for the cache RAM
//            port. Optional MAIN_MEMORY_STATS_EN adds read/write counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module main_memory
  import mem_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int LATENCY    = 4,
  parameter int WB_LATENCY = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_req,
  input  logic              ram_we,
  input  logic [ADDR_W-1:0] ram_address,
  input  line_t             ram_write_data,
  output logic              ram_ready,
  output line_t             ram_read_data,
  output logic              busy
`ifdef MAIN_MEMORY_STATS_EN
  ,
  output logic [31:0]       read_count,
  output logic [31:0]       write_count
`endif
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int MAX_LAT = (LATENCY > WB_LATENCY) ? LATENCY : WB_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] WB_LOAD = CNT_W'(WB_LATENCY - 1);

  mem_state_t       state;
  mem_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx_q;
  logic             we_q;
  line_t            wdata_q;
  logic             fire;
  logic [IDX_W-1:0] req_idx;
  logic             unused_addr_bits;

  assign req_idx          = ram_address[OFFSET_W +: IDX_W];
  assign unused_addr_bits = ^{ram_address[ADDR_W-1:OFFSET_W+IDX_W],
                              ram_address[OFFSET_W-1:0]};

  always_comb begin
    state_next = state;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        if (ram_req) state_next = ACCESS;
      end
      ACCESS: begin
        if (!ram_req) begin
          state_next = IDLE;
        end else if (cnt == '0) begin
          fire       = 1'b1;
          state_next = RESPOND;
        end
      end
      // The initiator still holds ram_req here, so it must not re-trigger.
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && ram_req) begin
        idx_q   <= req_idx;
        we_q    <= ram_we;
        wdata_q <= ram_write_data;
        cnt     <= ram_we ? WB_LOAD : RD_LOAD;
      end else if (state == ACCESS && ram_req && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign ram_ready = (state == RESPOND);
  assign busy      = (state != IDLE);

  // Reset must win over a write landing on the same edge.
  line_storage #(
    .DEPTH   (DEPTH)
  ) u_storage (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fire && we_q && !rst),
    .rd_en   (fire && !we_q),
    .idx     (idx_q),
    .wr_data (wdata_q),
    .rd_data (ram_read_data)
  );

`ifdef MAIN_MEMORY_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      read_count  <= '0;
      write_count <= '0;
    end else begin
      if (fire && !we_q && read_count != 32'hFFFF_FFFF) begin
        read_count <= read_count + 32'd1;
      end
      if (fire && we_q && write_count != 32'hFFFF_FFFF) begin
        write_count <= write_count + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_main_memory.sv
// ============================================================================
// Module   : tb_main_memory
// Brief    : Self-checking bench for main_memory against a line-array model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_main_memory;
  import mem_pkg::*;

  localparam int DEPTH  = 64;
  localparam int LAT    = 4;
  localparam int WB_LAT = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  line_t       wdata;
  logic        ready;
  line_t       rdata;
  logic        busy;
`ifdef MAIN_MEMORY_STATS_EN
  logic [31:0] read_count;
  logic [31:0] write_count;
`endif

  always #5 clk = ~clk;

  main_memory #(
    .DEPTH          (DEPTH),
    .LATENCY        (LAT),
    .WB_LATENCY     (WB_LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ram_req        (req),
    .ram_we         (we),
    .ram_address    (addr),
    .ram_write_data (wdata),
    .ram_ready      (ready),
    .ram_read_data  (rdata),
    .busy           (busy)
`ifdef MAIN_MEMORY_STATS_EN
    ,
    .read_count     (read_count),
    .write_count    (write_count)
`endif
  );

  line_t model_mem [DEPTH];
  bit    known     [DEPTH];
  line_t last_rd;
  int    n_vec = 0;
  int    n_err = 0;
  int    exp_rd = 0;
  int    exp_wr = 0;

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32'd64) % DEPTH);
  endfunction

  function automatic line_t rand_line();
    line_t r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic line_t fill_line(input logic [31:0] pat);
    line_t r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = pat;
    return r;
  endfunction

  task automatic check_line(input string tag, input line_t obs, input line_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Negedges from the drive point up to and including the ready cycle.
  task automatic wait_pulse(output int n);
    @(negedge clk);
    n = 1;
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Entered at a negedge with the DUT in IDLE; hold keeps ram_req high afterwards.
  task automatic access(input logic w, input logic [31:0] a, input line_t d, input bit hold);
    int n;
    int l;
    l     = line_of(a);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    wait_pulse(n);
    check_int(w ? "wr_latency" : "rd_latency", n, (w ? WB_LAT : LAT) + 1);
    if (w) begin
      check_line("rd_data_held_on_write", rdata, last_rd);
      model_mem[l] = d;
      known[l]     = 1'b1;
      exp_wr++;
    end else begin
      check_line("rd_data", rdata, model_mem[l]);
      last_rd = model_mem[l];
      exp_rd++;
    end
    if (!hold) req = 1'b0;
    @(negedge clk);
    check_int("ready_one_cycle", int'(ready), 0);
    check_int("busy_idle", int'(busy), 0);
  endtask

  initial begin
    int    seen;
    line_t old;
    logic [31:0] a;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    last_rd = '0;
    repeat (3) @(negedge clk);
    check_int("reset_ready", int'(ready), 0);
    check_int("reset_busy", int'(busy), 0);
    check_line("reset_rdata", rdata, '0);
    rst = 1'b0;
    @(negedge clk);

    // Basic write then read of line 1.
    access(1'b1, 32'h0000_0040, fill_line(32'hA5A5_A5A5), 1'b0);
    access(1'b0, 32'h0000_0040, '0, 1'b0);

    // Back-to-back write-back then fill with ram_req held throughout.
    access(1'b1, 32'h0000_0100, rand_line(), 1'b0);
    access(1'b1, 32'h0000_0080, rand_line(), 1'b1);
    access(1'b0, 32'h0000_0100, '0, 1'b0);

    // Upper address bits wrap onto line 0.
    access(1'b1, 32'h0000_1000, fill_line(32'h1234_5678), 1'b0);
    access(1'b0, 32'h0000_0000, '0, 1'b0);

    // Abort a write in its second ACCESS cycle.
    access(1'b1, 32'h0000_00C0, rand_line(), 1'b0);
    req = 1'b1; we = 1'b1; addr = 32'h0000_00C0; wdata = rand_line();
    @(negedge clk);
    @(negedge clk);
    req = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready === 1'b1) seen++;
    end
    check_int("abort_no_ready", seen, 0);
    check_int("abort_busy", int'(busy), 0);
    access(1'b0, 32'h0000_00C0, '0, 1'b0);

    // Reset in the middle of a read.
    req = 1'b1; we = 1'b0; addr = 32'h0000_0040; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    check_int("rst_read_ready", int'(ready), 0);
    check_int("rst_read_busy", int'(busy), 0);
    check_line("rst_read_rdata", rdata, '0);
    rst = 1'b0; last_rd = '0; exp_rd = 0; exp_wr = 0;
    @(negedge clk);
    access(1'b0, 32'h0000_0040, '0, 1'b0);

    // Reset on the very edge that would commit a write.
    req = 1'b1; we = 1'b1; addr = 32'h0000_0100; wdata = ~model_mem[4];
    repeat (WB_LAT) @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    check_int("rst_write_busy", int'(busy), 0);
    check_int("rst_write_ready", int'(ready), 0);
    rst = 1'b0; last_rd = '0; exp_rd = 0; exp_wr = 0;
    @(negedge clk);
    access(1'b0, 32'h0000_0100, '0, 1'b0);

    // Randomized traffic over a handful of lines with arbitrary upper bits.
    for (int t = 0; t < 40; t++) begin
      a       = $urandom;
      a[11:6] = 6'($urandom_range(0, 7));
      if (!known[line_of(a)] || ($urandom_range(0, 1) == 0)) begin
        access(1'b1, a, rand_line(), 1'b0);
      end else begin
        access(1'b0, a, '0, 1'b0);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef MAIN_MEMORY_STATS_EN
    check_int("read_count", int'(read_count), exp_rd);
    check_int("write_count", int'(write_count), exp_wr);
    force dut.write_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.write_count;
    old = rand_line();
    access(1'b1, 32'h0000_0140, old, 1'b0);
    check_int("write_count_sat", int'(write_count), -1);
`else
    old = '0;
    check_line("unused_old", old, '0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
